// File: rtl/spell_pkg.sv
// -----------------------------------------------------------------------------
// spell_pkg
// Shared types and constants for the spell RAM bus arbiter.
//   arb_state_t : arbiter FSM states
//   DEF_AW/DEF_DW : default word address / data widths
//   ERR_CNT_W   : width of the saturating timeout counter
//   idx_w()     : width of a channel index (at least 1 bit)
// -----------------------------------------------------------------------------
package spell_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam int DEF_AW    = 10;
  localparam int DEF_DW    = 32;
  localparam int ERR_CNT_W = 8;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spell_rr_picker.sv
// -----------------------------------------------------------------------------
// spell_rr_picker
// Combinational round-robin selector. The search starts at (last+1) mod
// NUM_CH and wraps, so the previous owner has the lowest priority.
// Ports:
//   req   in  NUM_CH  request vector
//   last  in  IW      index of the previous owner
//   gnt   out NUM_CH  one-hot winner (0 when no request)
//   idx   out IW      index of the winner
//   valid out 1       at least one request present
// -----------------------------------------------------------------------------
module spell_rr_picker
  import spell_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int IW     = idx_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IW-1:0]     last,
  output logic [NUM_CH-1:0] gnt,
  output logic [IW-1:0]     idx,
  output logic              valid
);

  int cand;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment; a path that leaves one unassigned infers a latch.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = (int'(last) + k) % NUM_CH;
      if (!valid && req[cand]) begin
        valid     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/spell_rambus_arbiter.sv
// -----------------------------------------------------------------------------
// spell_rambus_arbiter
// Shares the single spell RAM Wishbone bus among NUM_CH masters. Transfers
// are single-beat, arbitrated round-robin, and guarded by a bus timeout that
// answers the owner with m_err and pulses timeout_irq. Every output is a flop.
// Ports:
//   clock, reset (sync, active-low)
//   m_cyc/m_stb/m_we [NUM_CH], m_addr [NUM_CH*AW], m_wdata [NUM_CH*DW],
//   m_sel [NUM_CH*SW]                       : master requests (flattened)
//   m_ack/m_err [NUM_CH], m_rdata [DW]      : master responses
//   rambus_wb_*_o                           : RAM bus master side
//   rambus_wb_ack_i, rambus_wb_dat_i        : RAM bus responses
//   grant [NUM_CH]                          : one-hot current owner
//   timeout_irq                             : one-cycle pulse per timeout
//   err_count [8]                           : saturating timeout count
// -----------------------------------------------------------------------------
module spell_rambus_arbiter
  import spell_pkg::*;
#(
  parameter  int NUM_CH  = 2,
  parameter  int AW      = DEF_AW,
  parameter  int DW      = DEF_DW,
  parameter  int TIMEOUT = 255,
  localparam int SW      = DW / 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_CH-1:0]    m_cyc,
  input  logic [NUM_CH-1:0]    m_stb,
  input  logic [NUM_CH-1:0]    m_we,
  input  logic [NUM_CH*AW-1:0] m_addr,
  input  logic [NUM_CH*DW-1:0] m_wdata,
  input  logic [NUM_CH*SW-1:0] m_sel,
  output logic [NUM_CH-1:0]    m_ack,
  output logic [NUM_CH-1:0]    m_err,
  output logic [DW-1:0]        m_rdata,
  output logic                 rambus_wb_cyc_o,
  output logic                 rambus_wb_stb_o,
  output logic                 rambus_wb_we_o,
  output logic [AW-1:0]        rambus_wb_addr_o,
  output logic [DW-1:0]        rambus_wb_dat_o,
  output logic [SW-1:0]        rambus_wb_sel_o,
  input  logic                 rambus_wb_ack_i,
  input  logic [DW-1:0]        rambus_wb_dat_i,
  output logic [NUM_CH-1:0]    grant,
  output logic                 timeout_irq,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int IW    = idx_w(NUM_CH);
  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  arb_state_t           state_q, state_d;
  logic [IW-1:0]        last_q, last_d;
  logic [IW-1:0]        owner_q, owner_d;
  logic [NUM_CH-1:0]    grant_q, grant_d;
  logic                 cyc_q, cyc_d;
  logic                 stb_q, stb_d;
  logic                 we_q, we_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [DW-1:0]        wdat_q, wdat_d;
  logic [SW-1:0]        sel_q, sel_d;
  logic [NUM_CH-1:0]    ack_q, ack_d;
  logic [NUM_CH-1:0]    err_q, err_d;
  logic [DW-1:0]        rdata_q, rdata_d;
  logic                 irq_q, irq_d;
  logic [ERR_CNT_W-1:0] errcnt_q, errcnt_d;
  logic [CNT_W-1:0]     tcnt_q, tcnt_d;

  logic [NUM_CH-1:0]    req;
  logic [NUM_CH-1:0]    pick_gnt;
  logic [IW-1:0]        pick_idx;
  logic                 pick_valid;
  logic                 timeout_hit;

  assign req = m_cyc & m_stb;

  spell_rr_picker #(
    .NUM_CH (NUM_CH),
    .IW     (IW)
  ) u_picker (
    .req   (req),
    .last  (last_q),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // The counter reads 0 in the first BUS cycle, so the limit is hit in the
  // cycle where the next increment would reach TIMEOUT.
  assign timeout_hit = (TIMEOUT != 0) && ((int'(tcnt_q) + 1) == TIMEOUT);

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    owner_d  = owner_q;
    grant_d  = grant_q;
    cyc_d    = cyc_q;
    stb_d    = stb_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdat_d   = wdat_q;
    sel_d    = sel_q;
    rdata_d  = rdata_q;
    errcnt_d = errcnt_q;
    tcnt_d   = tcnt_q;
    ack_d    = '0;
    err_d    = '0;
    irq_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = pick_gnt;
          owner_d = pick_idx;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = m_we[pick_idx];
          addr_d  = m_addr[int'(pick_idx)*AW +: AW];
          wdat_d  = m_wdata[int'(pick_idx)*DW +: DW];
          sel_d   = m_sel[int'(pick_idx)*SW +: SW];
          tcnt_d  = '0;
          state_d = BUS;
        end
      end

      BUS: begin
        // Priority: RAM ack beats both abort and timeout.
        if (rambus_wb_ack_i) begin
          rdata_d        = rambus_wb_dat_i;
          ack_d[owner_q] = 1'b1;
          cyc_d          = 1'b0;
          stb_d          = 1'b0;
          last_d         = owner_q;
          state_d        = RESP;
        end else if (!m_cyc[owner_q]) begin
          // Abort: straight back to IDLE; a late RAM ack lands in IDLE and
          // is ignored.
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          grant_d = '0;
          last_d  = owner_q;
          state_d = IDLE;
        end else if (timeout_hit) begin
          err_d[owner_q] = 1'b1;
          irq_d          = 1'b1;
          if (errcnt_q != {ERR_CNT_W{1'b1}}) errcnt_d = errcnt_q + 1'b1;
          cyc_d          = 1'b0;
          stb_d          = 1'b0;
          last_d         = owner_q;
          state_d        = RESP;
        end else if (TIMEOUT != 0) begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end

      RESP: begin
        grant_d = '0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= IDLE;
      last_q   <= IW'(NUM_CH - 1);
      owner_q  <= '0;
      grant_q  <= '0;
      cyc_q    <= 1'b0;
      stb_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdat_q   <= '0;
      sel_q    <= '0;
      ack_q    <= '0;
      err_q    <= '0;
      rdata_q  <= '0;
      irq_q    <= 1'b0;
      errcnt_q <= '0;
      tcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      grant_q  <= grant_d;
      cyc_q    <= cyc_d;
      stb_q    <= stb_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdat_q   <= wdat_d;
      sel_q    <= sel_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      irq_q    <= irq_d;
      errcnt_q <= errcnt_d;
      tcnt_q   <= tcnt_d;
    end
  end

  assign m_ack            = ack_q;
  assign m_err            = err_q;
  assign m_rdata          = rdata_q;
  assign rambus_wb_cyc_o  = cyc_q;
  assign rambus_wb_stb_o  = stb_q;
  assign rambus_wb_we_o   = we_q;
  assign rambus_wb_addr_o = addr_q;
  assign rambus_wb_dat_o  = wdat_q;
  assign rambus_wb_sel_o  = sel_q;
  assign grant            = grant_q;
  assign timeout_irq      = irq_q;
  assign err_count        = errcnt_q;

endmodule

// File: tb/tb_spell_rambus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_spell_rambus_arbiter
// Directed bench for spell_rambus_arbiter (2 channels, TIMEOUT=4). The RAM
// side is driven by hand so ack timing is exact. Inputs change and outputs
// are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_spell_rambus_arbiter;

  localparam int NUM_CH  = 2;
  localparam int AW      = 10;
  localparam int DW      = 32;
  localparam int SW      = DW / 8;
  localparam int TIMEOUT = 4;

  logic                 clock = 1'b0;
  logic                 reset;
  logic [NUM_CH-1:0]    m_cyc, m_stb, m_we;
  logic [NUM_CH*AW-1:0] m_addr;
  logic [NUM_CH*DW-1:0] m_wdata;
  logic [NUM_CH*SW-1:0] m_sel;
  logic [NUM_CH-1:0]    m_ack, m_err;
  logic [DW-1:0]        m_rdata;
  logic                 rambus_wb_cyc_o, rambus_wb_stb_o, rambus_wb_we_o;
  logic [AW-1:0]        rambus_wb_addr_o;
  logic [DW-1:0]        rambus_wb_dat_o;
  logic [SW-1:0]        rambus_wb_sel_o;
  logic                 rambus_wb_ack_i;
  logic [DW-1:0]        rambus_wb_dat_i;
  logic [NUM_CH-1:0]    grant;
  logic                 timeout_irq;
  logic [7:0]           err_count;

  int n_checks = 0;
  int n_fail   = 0;

  spell_rambus_arbiter #(
    .NUM_CH  (NUM_CH),
    .AW      (AW),
    .DW      (DW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .m_cyc            (m_cyc),
    .m_stb            (m_stb),
    .m_we             (m_we),
    .m_addr           (m_addr),
    .m_wdata          (m_wdata),
    .m_sel            (m_sel),
    .m_ack            (m_ack),
    .m_err            (m_err),
    .m_rdata          (m_rdata),
    .rambus_wb_cyc_o  (rambus_wb_cyc_o),
    .rambus_wb_stb_o  (rambus_wb_stb_o),
    .rambus_wb_we_o   (rambus_wb_we_o),
    .rambus_wb_addr_o (rambus_wb_addr_o),
    .rambus_wb_dat_o  (rambus_wb_dat_o),
    .rambus_wb_sel_o  (rambus_wb_sel_o),
    .rambus_wb_ack_i  (rambus_wb_ack_i),
    .rambus_wb_dat_i  (rambus_wb_dat_i),
    .grant            (grant),
    .timeout_irq      (timeout_irq),
    .err_count        (err_count)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int ch, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, input logic [SW-1:0] sel);
    m_cyc[ch]              = 1'b1;
    m_stb[ch]              = 1'b1;
    m_we[ch]               = we;
    m_addr[ch*AW +: AW]    = addr;
    m_wdata[ch*DW +: DW]   = wd;
    m_sel[ch*SW +: SW]     = sel;
  endtask

  task automatic drop(input int ch);
    m_cyc[ch] = 1'b0;
    m_stb[ch] = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    int irqs;
    int cycles;
    reset           = 1'b0;
    m_cyc           = '0;
    m_stb           = '0;
    m_we            = '0;
    m_addr          = '0;
    m_wdata         = '0;
    m_sel           = '0;
    rambus_wb_ack_i = 1'b0;
    rambus_wb_dat_i = '0;
    tick();
    do_reset();
    tick();

    // Reset state
    check("rst_cyc",    rambus_wb_cyc_o, 0);
    check("rst_stb",    rambus_wb_stb_o, 0);
    check("rst_grant",  grant, 0);
    check("rst_errcnt", err_count, 0);
    check("rst_rdata",  m_rdata, 0);

    // Single read, ch0 @0x05, zero-wait RAM
    set_req(0, 1'b0, 10'h005, 32'h0, 4'hF);
    tick();                                   // cycle 1
    check("rd_grant", grant, 2'b01);
    check("rd_cyc",   rambus_wb_cyc_o, 1);
    check("rd_stb",   rambus_wb_stb_o, 1);
    check("rd_addr",  rambus_wb_addr_o, 10'h005);
    check("rd_we",    rambus_wb_we_o, 0);
    rambus_wb_ack_i = 1'b1;
    rambus_wb_dat_i = 32'hDEADBEEF;
    tick();                                   // cycle 2
    rambus_wb_ack_i = 1'b0;
    rambus_wb_dat_i = '0;
    check("rd_ack",       m_ack, 2'b01);
    check("rd_rdata",     m_rdata, 32'hDEADBEEF);
    check("rd_stb_low",   rambus_wb_stb_o, 0);
    check("rd_grant_rsp", grant, 2'b01);
    drop(0);
    tick();                                   // cycle 3
    check("rd_ack_low",   m_ack, 0);
    check("rd_grant_clr", grant, 0);

    // Round-robin with both channels requesting from reset
    do_reset();
    set_req(0, 1'b0, 10'h010, 32'h0, 4'hF);
    set_req(1, 1'b0, 10'h020, 32'h0, 4'hF);
    for (int i = 0; i < 4; i++) begin
      logic [1:0] exp_g;
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      tick();
      check($sformatf("rr_grant%0d", i), grant, exp_g);
      rambus_wb_ack_i = 1'b1;
      rambus_wb_dat_i = 32'h100 + i;
      tick();
      rambus_wb_ack_i = 1'b0;
      check($sformatf("rr_ack%0d", i), m_ack, exp_g);
      tick();
      check($sformatf("rr_idle%0d", i), grant, 0);
    end
    drop(0);
    drop(1);

    // Write on ch1, outputs held while the master changes its inputs
    set_req(1, 1'b1, 10'h3FF, 32'h12345678, 4'b0101);
    tick();                                   // cycle 1
    check("wr_grant", grant, 2'b10);
    check("wr_we",    rambus_wb_we_o, 1);
    check("wr_addr",  rambus_wb_addr_o, 10'h3FF);
    check("wr_dat",   rambus_wb_dat_o, 32'h12345678);
    check("wr_sel",   rambus_wb_sel_o, 4'b0101);
    m_addr[AW +: AW]  = 10'h000;
    m_wdata[DW +: DW] = 32'h0;
    m_sel[SW +: SW]   = 4'h0;
    tick();
    tick();                                   // cycle 3
    check("wr_hold_stb",  rambus_wb_stb_o, 1);
    check("wr_hold_addr", rambus_wb_addr_o, 10'h3FF);
    check("wr_hold_dat",  rambus_wb_dat_o, 32'h12345678);
    check("wr_hold_sel",  rambus_wb_sel_o, 4'b0101);
    rambus_wb_ack_i = 1'b1;
    tick();                                   // cycle 4
    rambus_wb_ack_i = 1'b0;
    check("wr_ack", m_ack, 2'b10);
    drop(1);
    tick();

    // Timeout with TIMEOUT=4: m_err at cycle 5
    do_reset();
    set_req(0, 1'b0, 10'h001, 32'h0, 4'hF);
    tick();                                   // cycle 1
    check("to_stb", rambus_wb_stb_o, 1);
    tick();
    tick();
    tick();                                   // cycle 4
    check("to_err_early", m_err, 0);
    tick();                                   // cycle 5
    check("to_err",    m_err, 2'b01);
    check("to_irq",    timeout_irq, 1);
    check("to_cnt",    err_count, 1);
    check("to_stb_lo", rambus_wb_stb_o, 0);
    check("to_no_ack", m_ack, 0);
    drop(0);
    tick();                                   // cycle 6
    check("to_irq_pulse", timeout_irq, 0);
    check("to_err_pulse", m_err, 0);

    // Ack in the very cycle the timeout would fire: ack wins
    tick();
    set_req(0, 1'b0, 10'h002, 32'h0, 4'hF);
    tick();                                   // cycle 1
    tick();
    tick();
    tick();                                   // cycle 4
    rambus_wb_ack_i = 1'b1;
    rambus_wb_dat_i = 32'hA5A5A5A5;
    tick();                                   // cycle 5
    rambus_wb_ack_i = 1'b0;
    rambus_wb_dat_i = '0;
    check("race_ack",   m_ack, 2'b01);
    check("race_err",   m_err, 0);
    check("race_irq",   timeout_irq, 0);
    check("race_cnt",   err_count, 1);
    check("race_rdata", m_rdata, 32'hA5A5A5A5);
    drop(0);
    tick();

    // Saturation: 300 timeouts in total keep err_count at 255
    irqs   = 1;
    cycles = 0;
    set_req(0, 1'b0, 10'h003, 32'h0, 4'hF);
    while (irqs < 300 && cycles < 3000) begin
      tick();
      cycles++;
      if (timeout_irq) irqs++;
    end
    drop(0);
    check("sat_irqs", irqs, 300);
    check("sat_cnt",  err_count, 8'd255);
    tick();
    tick();
    tick();
    check("sat_idle", rambus_wb_cyc_o, 0);

    // Abort: owner drops m_cyc in BUS, late RAM ack is ignored
    set_req(1, 1'b0, 10'h004, 32'h0, 4'hF);
    tick();                                   // cycle 1
    check("ab_grant", grant, 2'b10);
    drop(1);
    tick();                                   // cycle 2
    check("ab_cyc_lo",   rambus_wb_cyc_o, 0);
    check("ab_grant_lo", grant, 0);
    tick();                                   // cycle 3
    rambus_wb_ack_i = 1'b1;
    rambus_wb_dat_i = 32'hFFFF0000;
    tick();                                   // cycle 4
    rambus_wb_ack_i = 1'b0;
    rambus_wb_dat_i = '0;
    check("ab_no_ack", m_ack, 0);
    check("ab_no_err", m_err, 0);
    check("ab_rdata",  m_rdata, 32'hA5A5A5A5);
    set_req(0, 1'b0, 10'h006, 32'h0, 4'hF);
    tick();
    check("ab_next_grant", grant, 2'b01);
    rambus_wb_ack_i = 1'b1;
    rambus_wb_dat_i = 32'hCAFEF00D;
    tick();
    rambus_wb_ack_i = 1'b0;
    check("ab_next_ack",   m_ack, 2'b01);
    check("ab_next_rdata", m_rdata, 32'hCAFEF00D);
    drop(0);
    tick();

    // Reset during BUS, then ch0 beats ch1
    set_req(1, 1'b1, 10'h007, 32'h11111111, 4'hF);
    tick();
    check("mr_stb", rambus_wb_stb_o, 1);
    reset = 1'b0;
    set_req(0, 1'b0, 10'h008, 32'h0, 4'hF);
    tick();
    check("mr_cyc",   rambus_wb_cyc_o, 0);
    check("mr_stb0",  rambus_wb_stb_o, 0);
    check("mr_grant", grant, 0);
    check("mr_ack",   m_ack, 0);
    check("mr_cnt",   err_count, 0);
    check("mr_rdata", m_rdata, 0);
    check("mr_addr",  rambus_wb_addr_o, 0);
    reset = 1'b1;
    tick();
    check("mr_prio", grant, 2'b01);
    rambus_wb_ack_i = 1'b1;
    tick();
    rambus_wb_ack_i = 1'b0;
    check("mr_prio_ack", m_ack, 2'b01);
    drop(0);
    drop(1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spell_rambus_arbiter.md
# spell_rambus_arbiter

Parametrised N-channel round-robin arbiter that shares the single spell RAM Wishbone bus (rambus) among several masters (spell core, host Wishbone bridge, LA debug port). Generalises the single-master rambus of the current generation in channel count, address/data width and fault handling: each transfer is single-beat, arbitrated fairly, and guarded by a bus timeout that returns an error and raises an interrupt. Sits between the masters and the RAM macro inside the user project.

## Interface
Parameters:
- NUM_CH, 2, number of masters (1..8)
- AW, 10, word address width
- DW, 32, data width (multiple of 8); SW = DW/8 select lanes
- TIMEOUT, 255, max cycles waiting for rambus ack; 0 disables timeout

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset
- m_cyc  in  NUM_CH  per-master cycle
- m_stb  in  NUM_CH  per-master strobe
- m_we  in  NUM_CH  per-master write enable
- m_addr  in  NUM_CH*AW  flattened addresses, channel i at [i*AW +: AW]
- m_wdata  in  NUM_CH*DW  flattened write data
- m_sel  in  NUM_CH*SW  flattened byte selects
- m_ack  out  NUM_CH  one-cycle ack to owner
- m_err  out  NUM_CH  one-cycle error (timeout) to owner
- m_rdata  out  DW  read data, shared, valid with m_ack
- rambus_wb_cyc_o / rambus_wb_stb_o / rambus_wb_we_o  out  1 each
- rambus_wb_addr_o  out  AW
- rambus_wb_dat_o  out  DW
- rambus_wb_sel_o  out  SW
- rambus_wb_ack_i  in  1
- rambus_wb_dat_i  in  DW
- grant  out  NUM_CH  one-hot current owner (0 in IDLE)
- timeout_irq  out  1  one-cycle pulse per timeout
- err_count  out  8  saturating timeout counter

## Operation
- Request for channel i = m_cyc[i] & m_stb[i].
- FSM states IDLE, BUS, RESP.
- IDLE: if any request, pick winner by round-robin starting at (last+1) mod NUM_CH; register grant, addr, wdata, sel, we onto rambus outputs; assert cyc/stb; clear timeout counter; -> BUS. No request: stay.
- BUS: cyc/stb held; outputs stable.
  - rambus_wb_ack_i=1: latch rambus_wb_dat_i into m_rdata, m_ack[owner]=1 next cycle, drop cyc/stb, last=owner, -> RESP.
  - owner drops m_cyc (abort): drop cyc/stb next cycle, no ack/err, last=owner, -> IDLE; a later rambus ack is ignored.
  - counter reaches TIMEOUT (TIMEOUT≠0): m_err[owner]=1, timeout_irq=1, err_count+1 (saturate at 255), drop cyc/stb, last=owner, -> RESP.
  - ack and timeout in same cycle: ack wins. ack and abort same cycle: ack wins.
- RESP: m_ack/m_err deassert, grant cleared, -> IDLE (one-cycle turnaround; master must drop stb on ack/err).
- Reset: all outputs 0, m_rdata 0, err_count 0, state IDLE, last = NUM_CH-1 (channel 0 highest priority). Reset mid-transfer drops cyc immediately, no ack.
- NUM_CH=1: arbitration degenerates to pass-through with same timing.

## Timing
- Request seen cycle 0 -> rambus cyc/stb and grant at cycle 1.
- rambus ack at cycle k -> m_ack, m_rdata at k+1; rambus stb low at k+1.
- Timeout: stb asserted at cycle 1, counter increments each BUS cycle; m_err at cycle TIMEOUT+1.
- Max throughput: one transfer per 3 cycles with zero-wait RAM (ack at cycle 1).
- All outputs registered; no combinational path from m_* to rambus_* or from rambus_wb_ack_i to m_ack.

## Structure
- spell_pkg: arb_state_t enum (IDLE, BUS, RESP), default AW/DW constants, ERR_CNT_W=8.
- Sub-module spell_rr_picker: combinational round-robin select (req vector, last index -> one-hot grant, valid); parametrised by NUM_CH.
- Timeout counter width $clog2(TIMEOUT+1), minimum 1.

## Test plan
- Single read ch0 addr 0x05, RAM acks cycle 1 with 0xDEADBEEF -> m_ack[0] at cycle 2, m_rdata=0xDEADBEEF, grant=01 then 00.
- ch0 and ch1 request continuously from reset -> grants alternate 0,1,0,1; no channel granted twice in a row.
- Write ch1 addr 0x3FF, data 0x12345678, sel 0b0101 -> rambus_wb_* carries exact values, we=1, held stable until ack.
- TIMEOUT=4, RAM never acks -> m_err[owner] at cycle 5, timeout_irq one pulse, err_count=1; 300 timeouts -> err_count stays 255.
- Owner drops m_cyc in BUS, RAM acks two cycles later -> no m_ack, cyc low next cycle, next request served normally.
- reset low during BUS -> all outputs 0 next cycle; after release ch0 wins over simultaneous ch1.
